// File: rtl/iob_fifo2axis.sv
// iob_fifo2axis: drains a 1-cycle-latency FIFO read port into an AXI-Stream master.
// A 2-entry register buffer absorbs the read latency. Reads are only issued when the
// buffer is guaranteed to have room for the returning word. tlast is generated from
// a programmable packet length.
module iob_fifo2axis #(
  parameter int DATA_W = 21,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              fifo_read_o,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic [DATA_W-1:0] axis_tdata_o,
  output logic              axis_tvalid_o,
  input  logic              axis_tready_i,
  output logic              axis_tlast_o,
  output logic [LEN_W-1:0]  count_o,
  output logic              done_o
);

  localparam int DEPTH = 2;

  // Registered state and next-state values
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf_q [DEPTH];
  logic [DATA_W-1:0] buf_d [DEPTH];
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              done_q, done_d;

  // Combinational helpers
  logic              pop;
  logic              last_hit;
  logic [2:0]        pending;
  logic [1:0]        wr_idx;

  assign axis_tvalid_o = (occ_q != 2'd0);
  assign axis_tdata_o  = buf_q[0];
  assign count_o       = cnt_q;
  assign done_o        = done_q;

  // Handshake, credit check and tlast decode
  always_comb begin
    pop      = axis_tvalid_o & axis_tready_i;
    // Words that will still occupy the buffer after this cycle: buffered plus
    // the one returning from the FIFO, minus the one leaving on the stream.
    pending  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    last_hit = (len_q != '0) && (cnt_q == len_q - LEN_W'(1));
    axis_tlast_o = axis_tvalid_o & last_hit;
    fifo_read_o  = cke_i & en_i & ~fifo_empty_i & ~rst_i & ~arst_i & (pending < 3'd2);
    // Slot the returning word lands in once the head has (possibly) left
    wr_idx   = occ_q - {1'b0, pop};
  end

  // Next-state: buffer shift/fill, occupancy, packet counter, length latch, done
  always_comb begin
    inflight_d = inflight_q;
    occ_d      = occ_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    done_d     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      buf_d[i] = buf_q[i];
    end

    if (rst_i) begin
      // The word in flight is dropped: inflight is cleared and never pushed
      inflight_d = 1'b0;
      occ_d      = 2'd0;
      cnt_d      = '0;
      len_d      = '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_d[i] = '0;
      end
    end else begin
      inflight_d = fifo_read_o;
      if (pop) begin
        buf_d[0] = buf_q[1];
      end
      if (inflight_q) begin
        if (wr_idx == 2'd0) begin
          buf_d[0] = fifo_data_i;
        end else begin
          buf_d[1] = fifo_data_i;
        end
      end
      occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};

      if (pop) begin
        cnt_d = axis_tlast_o ? '0 : cnt_q + LEN_W'(1);
      end
      // Length is only sampled between packets so a packet keeps its length
      if (cnt_q == '0) begin
        len_d = len_i;
      end
      done_d = pop & axis_tlast_o;
    end
  end

  // Control registers; cke_i low freezes everything
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      cnt_q      <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
    end else if (cke_i) begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      done_q     <= done_d;
    end
  end

  // One data register per buffer entry
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
    // Buffer entry gi
    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
        buf_q[gi] <= '0;
      end else if (cke_i) begin
        buf_q[gi] <= buf_d[gi];
      end
    end
  end

endmodule

// File: tb/tb_iob_fifo2axis.sv
// Testbench for iob_fifo2axis: FIFO model feeds the DUT, every word read from the
// FIFO is pushed to a scoreboard with its expected packet index and tlast; a monitor
// checks the stream, read strobe, latency, done pulse and stall/freeze stability.
module tb_iob_fifo2axis;

  localparam int DW = 21;
  localparam int LW = 16;
  localparam int MAXW = 4096;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          cke = 1'b1;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          tready = 1'b0;
  logic [LW-1:0] len = 16'd4;
  logic          fifo_read;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic [LW-1:0] count;
  logic          done;

  always #5 clk = ~clk;

  iob_fifo2axis #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .cke_i        (cke),
    .rst_i        (rst),
    .en_i         (en),
    .len_i        (len),
    .fifo_read_o  (fifo_read),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .axis_tdata_o (tdata),
    .axis_tvalid_o(tvalid),
    .axis_tready_i(tready),
    .axis_tlast_o (tlast),
    .count_o      (count),
    .done_o       (done)
  );

  // Source FIFO model (written by stimulus, read by the FIFO process)
  logic [DW-1:0] mem [MAXW];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  // Scoreboard: expected beats in read order
  logic [DW-1:0] exp_data [MAXW];
  logic          exp_last [MAXW];
  logic [LW-1:0] exp_idx  [MAXW];
  int            exp_edge [MAXW];
  int            exp_wr = 0;
  int            exp_rd = 0;
  int            edge_cnt = 0;
  logic [LW-1:0] pkt_idx = '0;

  int n_checks = 0;
  int n_fail = 0;
  int beat_no = 0;
  logic timeout_hit = 1'b0;

  // FIFO read port and expectation generation: the k-th word of a packet is
  // last when len != 0 and k == len-1
  always @(posedge clk) begin
    if (cke) edge_cnt <= edge_cnt + 1;
    if (arst || (rst && cke)) begin
      pkt_idx <= '0;
    end else if (fifo_read && rd_ptr < wr_ptr) begin
      fifo_data          <= mem[rd_ptr];
      rd_ptr             <= rd_ptr + 1;
      exp_data[exp_wr]   <= mem[rd_ptr];
      exp_last[exp_wr]   <= (len != 0) && (pkt_idx == len - 1);
      exp_idx[exp_wr]    <= pkt_idx;
      exp_edge[exp_wr]   <= edge_cnt + 1;
      exp_wr             <= exp_wr + 1;
      pkt_idx            <= ((len != 0) && (pkt_idx == len - 1)) ? '0 : pkt_idx + 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor state
  logic          done_exp = 1'b0;
  logic          rst_pend = 1'b1;
  logic          prev_stall = 1'b0;
  logic          prev_frozen = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [LW-1:0] prev_count = '0;
  logic          has_w, v_exp, pop_exp, rd_exp;
  int            outst;

  // Monitor: samples 1ns before each rising edge
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (arst) begin
        chk("read_in_arst", {31'd0, fifo_read}, 32'd0);
        rst_pend    = 1'b1;
        done_exp    = 1'b0;
        exp_rd      = exp_wr;
        prev_stall  = 1'b0;
        prev_frozen = 1'b0;
      end else begin
        has_w   = (exp_rd != exp_wr);
        v_exp   = has_w && (edge_cnt > exp_edge[exp_rd]);
        outst   = exp_wr - exp_rd;
        pop_exp = v_exp && tready && cke;
        rd_exp  = cke && en && !fifo_empty && !rst && ((outst - (pop_exp ? 1 : 0)) < 2);
        chk("fifo_read", {31'd0, fifo_read}, {31'd0, rd_exp});
        chk("outstanding_le_2", {31'd0, (outst <= 2)}, 32'd1);
        chk("tvalid", {31'd0, tvalid}, {31'd0, v_exp});
        chk("done", {31'd0, done}, {31'd0, done_exp});
        if (rst_pend) begin
          chk("rst_tdata", {11'd0, tdata}, 32'd0);
          chk("rst_count", {16'd0, count}, 32'd0);
        end
        if (v_exp) begin
          chk("tdata", {11'd0, tdata}, {11'd0, exp_data[exp_rd]});
          chk("tlast", {31'd0, tlast}, {31'd0, exp_last[exp_rd]});
          chk("count", {16'd0, count}, {16'd0, exp_idx[exp_rd]});
        end else begin
          chk("tlast_idle", {31'd0, tlast}, 32'd0);
        end
        if (!has_w && !rst_pend) chk("count_idle", {16'd0, count}, {16'd0, pkt_idx});
        if (prev_stall) chk("stall_tdata", {11'd0, tdata}, {11'd0, prev_data});
        if (prev_frozen) begin
          chk("frozen_tdata", {11'd0, tdata}, {11'd0, prev_data});
          chk("frozen_count", {16'd0, count}, {16'd0, prev_count});
        end
        chk("drain_timeout", {31'd0, timeout_hit}, 32'd0);

        if (pop_exp && !rst)
          $display("beat %0d data=0x%0h last=%0b count=%0d", beat_no++, tdata, tlast, count);

        if (cke) begin
          if (rst) begin
            done_exp = 1'b0;
            exp_rd   = exp_wr;
            rst_pend = 1'b1;
          end else begin
            done_exp = pop_exp && exp_last[exp_rd];
            if (pop_exp) exp_rd++;
            rst_pend = 1'b0;
          end
        end
        prev_stall  = cke && !rst && tvalid && !tready;
        prev_frozen = !cke;
        prev_data   = tdata;
        prev_count  = count;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (!(rd_ptr == wr_ptr && exp_rd == exp_wr) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (!(rd_ptr == wr_ptr && exp_rd == exp_wr)) timeout_hit = 1'b1;
    tick(2);
  endtask

  task automatic pulse_rst(input logic [LW-1:0] new_len);
    cke = 1'b1;
    rst = 1'b1;
    len = new_len;
    tick(1);
    rst = 1'b0;
  endtask

  logic [5:0]    pat = 6'b101001;
  logic [LW-1:0] lens [4];
  int            s, c;

  initial begin
    lens[0] = 16'd1; lens[1] = 16'd3; lens[2] = 16'd0; lens[3] = 16'd5;
    tick(3);
    arst = 1'b0;
    tick(2);

    // 1: preloaded 1..8, len 4, tready high
    for (int i = 1; i <= 8; i++) load(DW'(i));
    tready = 1'b1;
    en = 1'b1;
    wait_idle(60);

    // 2: same data with tready pattern 1,0,0,1,0,1
    for (int i = 1; i <= 8; i++) load(DW'(i));
    c = 0;
    while (!(rd_ptr == wr_ptr && exp_rd == exp_wr) && c < 200) begin
      tready = pat[c % 6];
      tick(1);
      c++;
    end
    if (!(rd_ptr == wr_ptr && exp_rd == exp_wr)) timeout_hit = 1'b1;
    tready = 1'b1;
    tick(2);

    // 3: empty for 10 cycles, then a single word
    tick(10);
    load(DW'(32'hAA));
    wait_idle(30);

    // 4: en dropped while stalled, then drain
    tready = 1'b0;
    for (int i = 0; i < 5; i++) load(DW'(32'h10 + i));
    tick(6);
    en = 1'b0;
    tick(4);
    tready = 1'b1;
    c = 0;
    while (exp_rd != exp_wr && c < 20) begin tick(1); c++; end
    if (exp_rd != exp_wr) timeout_hit = 1'b1;
    tick(3);
    en = 1'b1;
    wait_idle(40);

    // 5: synchronous reset mid-packet with the buffer full
    pulse_rst(16'd4);
    for (int i = 0; i < 6; i++) load(DW'(32'h40 + i));
    s = exp_rd;
    c = 0;
    while (exp_rd < s + 2 && c < 40) begin tick(1); c++; end
    if (exp_rd < s + 2) timeout_hit = 1'b1;
    tready = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tready = 1'b1;
    wait_idle(60);

    // 6: clock enable low mid-stream
    for (int i = 0; i < 20; i++) load(DW'(32'h100 + i));
    tick(5);
    cke = 1'b0;
    tick(5);
    cke = 1'b1;
    wait_idle(80);

    // Randomized traffic with several packet lengths
    for (int li = 0; li < 4; li++) begin
      pulse_rst(lens[li]);
      repeat (150) begin
        if ($urandom_range(0, 1) == 1) load(DW'($urandom));
        tready = ($urandom_range(0, 3) != 0);
        en     = ($urandom_range(0, 7) != 0);
        cke    = ($urandom_range(0, 9) != 0);
        tick(1);
      end
      cke = 1'b1;
      en = 1'b1;
      tready = 1'b1;
      wait_idle(600);
    end

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
